ifu_fetch_buffer: RTL and testbench

Instruction-fetch front end on the consumer side of the program-counter path. It owns the fetch address and issues sequential fetch requests to instruction memory over a request/grant/response handshake. Returned instructions are buffered in an in-order FIFO together with their PC and handed to decode over a valid/ready interface. A redirect from execute (branch/jump) flushes the buffer and restarts fetch at the new target.

---
 rtl/ifu_fetch_buffer.sv | 120 ++++++++++++
 tb/tb_ifu_fetch_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_fetch_buffer
//  Purpose  : Instruction-fetch front end. Owns the fetch PC, issues
//             sequential requests to instruction memory under a credit limit,
//             buffers returned words with their PC in an in-order FIFO for
//             decode, and flushes/restarts on an execute redirect.
//  Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   input  logic        id_ready
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = $clog2(DEPTH) + 1;

   logic [31:0]        r_fetch_pc;
   logic [c_CNT_W-1:0] r_inflight;
   logic [c_CNT_W-1:0] r_drop;
   logic [c_CNT_W-1:0] r_count;
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W-1:0] r_pq_wr;
   logic [c_PTR_W-1:0] r_pq_rd;
   logic [31:0]        r_pq       [DEPTH];
   logic [31:0]        r_fifo_pc  [DEPTH];
   logic [31:0]        r_fifo_ins [DEPTH];

   logic               w_credit;
   logic               w_accept;
   logic               w_keep;
   logic               w_drop_resp;
   logic               w_pop;
   logic [c_CNT_W:0]   w_used;

   // Requests already in flight plus buffered entries may never exceed DEPTH,
   // which guarantees every kept response has a free FIFO slot.
   assign w_used      = {1'b0, r_inflight} + {1'b0, r_count};
   assign w_credit    = w_used < (c_CNT_W + 1)'(DEPTH);
   assign imem_req    = !rst && !redirect && w_credit;
   assign imem_addr   = r_fetch_pc;

   assign w_accept    = imem_req && imem_gnt;
   assign w_keep      = imem_rvalid && !redirect && (r_drop == '0);
   assign w_drop_resp = imem_rvalid && (r_drop != '0);
   assign w_pop       = id_valid && id_ready && !redirect;

   assign id_valid    = (r_count != '0);
   assign id_pc       = id_valid ? r_fifo_pc[r_rd_ptr]  : 32'h0;
   assign id_instr    = id_valid ? r_fifo_ins[r_rd_ptr] : 32'h0;

   // Control state: fetch PC, counters and queue pointers; redirect dominates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_inflight <= '0;
         r_drop     <= '0;
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_pq_wr    <= '0;
         r_pq_rd    <= '0;
      end else if (redirect) begin
         // Everything still outstanding (less a response landing now) will
         // come back stale and must be discarded.
         r_fetch_pc <= redirect_pc;
         r_inflight <= r_inflight - c_CNT_W'(imem_rvalid);
         r_drop     <= r_inflight - c_CNT_W'(imem_rvalid);
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_pq_wr    <= '0;
         r_pq_rd    <= '0;
      end else begin
         if (w_accept) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_pq_wr    <= r_pq_wr + c_PTR_W'(1);
         end
         if (w_keep) begin
            r_pq_rd  <= r_pq_rd + c_PTR_W'(1);
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         r_inflight <= r_inflight + c_CNT_W'(w_accept) - c_CNT_W'(imem_rvalid);
         r_drop     <= r_drop - c_CNT_W'(w_drop_resp);
         r_count    <= r_count + c_CNT_W'(w_keep) - c_CNT_W'(w_pop);
      end
   end

   // Data storage: pending-PC queue and instruction FIFO; validity is tracked
   // by the pointers and counters, so no reset is needed here.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_pq[r_pq_wr] <= r_fetch_pc;
      end
      if (w_keep) begin
         r_fifo_pc[r_wr_ptr]  <= r_pq[r_pq_rd];
         r_fifo_ins[r_wr_ptr] <= imem_rdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifu_fetch_buffer
//  Purpose  : Self-checking bench for ifu_fetch_buffer with an in-order
//             variable-latency memory model and a PC/instruction scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch_buffer;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_ready;

   ifu_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_dut (
      .clk(clk), .rst(rst),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
      .id_ready(id_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   req_t        mq[$];      // outstanding memory requests, in order
   logic [31:0] sb_q[$];    // expected PCs delivered to decode
   logic [31:0] exp_fetch;
   int          n_vec, n_err;
   int          cyc;
   int          lat_min, lat_max, gnt_pct, rdy_mode;
   int          n_grants, n_pops;
   logic [31:0] last_pop, last_grant;
   bit          seen_wrap;

   function automatic logic [31:0] memw(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs after the edge, then observe settled outputs.
   task automatic step(input bit do_redir, input logic [31:0] tgt);
      logic [31:0] pc;
      @(posedge clk);
      #1;
      cyc++;
      redirect    = do_redir;
      redirect_pc = tgt;
      imem_gnt    = ($urandom_range(99) < gnt_pct);
      id_ready    = (rdy_mode == 2) ? 1'($urandom_range(1)) : 1'(rdy_mode);
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = memw(mq[0].addr);
      end
      #1;
      if (imem_rvalid) begin
         assert (mq.size() > 0) else $error("response with no outstanding request");
         void'(mq.pop_front());
      end
      if (do_redir) begin
         chk("req_in_redirect", 32'(imem_req), 32'h0);
         sb_q.delete();
         exp_fetch = tgt;
      end else begin
         if (imem_req && imem_gnt) begin
            chk("imem_addr", imem_addr, exp_fetch);
            if (n_grants > 0 && last_grant == 32'hFFFF_FFFC && imem_addr == 32'h0)
               seen_wrap = 1'b1;
            last_grant = imem_addr;
            mq.push_back('{addr: imem_addr,
                           due: cyc + int'($urandom_range(lat_max, lat_min))});
            sb_q.push_back(exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            n_grants++;
         end
         if (id_valid && id_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_pop", id_pc, 32'hDEAD_BEEF);
            end else begin
               pc = sb_q.pop_front();
               chk("id_pc", id_pc, pc);
               chk("id_instr", id_instr, memw(pc));
            end
            last_pop = id_pc;
            n_pops++;
         end
      end
   endtask

   task automatic clear_model();
      mq.delete();
      sb_q.delete();
      exp_fetch   = RESET_PC;
      n_grants    = 0;
      n_pops      = 0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      id_ready    = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_model();
      @(posedge clk);
      #1;
      chk("rst_req",   32'(imem_req), 32'h0);
      chk("rst_addr",  imem_addr, RESET_PC);
      chk("rst_valid", 32'(id_valid), 32'h0);
      chk("rst_pc",    id_pc, 32'h0);
      chk("rst_instr", id_instr, 32'h0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      n_vec = 0; n_err = 0; cyc = 0; seen_wrap = 1'b0;
      last_pop = 32'h0; last_grant = 32'h0;
      lat_min = 1; lat_max = 1; gnt_pct = 100; rdy_mode = 1;
      rst = 1'b1;
      clear_model();

      // 1: streaming with one-cycle memory and decode always ready
      do_reset();
      for (int i = 0; i < 20; i++) step(1'b0, 32'h0);
      chk("t1_pops", n_pops, 18);

      // 2: decode stall fills exactly DEPTH credits, then resumes at 0x10
      do_reset();
      rdy_mode = 0;
      for (int i = 0; i < 12; i++) step(1'b0, 32'h0);
      chk("t2_grants", n_grants, DEPTH);
      chk("t2_req",    32'(imem_req), 32'h0);
      chk("t2_head",   id_pc, 32'h0);
      chk("t2_instr",  id_instr, memw(32'h0));
      chk("t2_next",   exp_fetch, 32'h10);
      rdy_mode = 1;
      for (int i = 0; i < 20; i++) step(1'b0, 32'h0);
      chk("t2_resume_pops", n_pops, n_grants - int'(sb_q.size()));

      // 3: redirect with two requests in flight, then back-to-back redirects
      do_reset();
      lat_min = 5; lat_max = 5;
      step(1'b0, 32'h0);
      step(1'b0, 32'h0);
      chk("t3_inflight", mq.size(), 2);
      step(1'b1, 32'h0000_0100);
      n_pops = 0;
      for (int i = 0; i < 40 && n_pops == 0; i++) step(1'b0, 32'h0);
      chk("t3_first_pc", last_pop, 32'h100);
      step(1'b1, 32'h0000_0200);
      step(1'b1, 32'h0000_0300);
      n_pops = 0;
      for (int i = 0; i < 40 && n_pops == 0; i++) step(1'b0, 32'h0);
      chk("t3_b2b_pc", last_pop, 32'h300);

      // 4: random latency, grant stalls and decode stalls
      lat_min = 1; lat_max = 5; gnt_pct = 70; rdy_mode = 2;
      n_pops = 0;
      for (int i = 0; i < 6000 && n_pops < 200; i++) step(1'b0, 32'h0);
      chk("t4_done", 32'(n_pops >= 200), 32'h1);

      // 5: fetch address wraps past the top of the address space
      gnt_pct = 100; lat_min = 1; lat_max = 2; rdy_mode = 1;
      step(1'b1, 32'hFFFF_FFF8);
      for (int i = 0; i < 12; i++) step(1'b0, 32'h0);
      chk("t5_wrap", 32'(seen_wrap), 32'h1);

      // 6: asynchronous reset with the FIFO full
      lat_min = 1; lat_max = 1; rdy_mode = 0;
      step(1'b1, 32'h0000_4000);
      for (int i = 0; i < 10; i++) step(1'b0, 32'h0);
      chk("t6_full",  32'(id_valid), 32'h1);
      chk("t6_head",  id_pc, 32'h4000);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("t6_req",   32'(imem_req), 32'h0);
      chk("t6_valid", 32'(id_valid), 32'h0);
      chk("t6_pc",    id_pc, 32'h0);
      chk("t6_instr", id_instr, 32'h0);
      chk("t6_addr",  imem_addr, RESET_PC);
      clear_model();
      @(negedge clk);
      rst = 1'b0;
      rdy_mode = 1;
      n_pops = 0;
      for (int i = 0; i < 20 && n_pops == 0; i++) step(1'b0, 32'h0);
      chk("t6_restart_pc", last_pop, RESET_PC);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
